// File: rtl/hiscore_pkg.sv
// Shared types for the hiscore RAM arbiter: FSM states and byte-lane enables.
package hiscore_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } hs_arb_state_t;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;

  // Little-endian lane select from the byte-address LSB.
  function automatic logic [1:0] lane_be(input logic lane);
    return lane ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/hs_rd_pipe.sv
// Read-return tracker: DEPTH-cycle shift of a valid bit and the byte-lane bit.
// Fixed DEPTH latency, no backpressure; flushed by reset.
module hs_rd_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_memory,
  input  logic reset_n,
  input  logic in_vld,
  input  logic in_lane,
  output logic out_vld,
  output logic out_lane
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] lane_q, lane_d;

  always_comb begin
    vld_d     = vld_q;
    lane_d    = lane_q;
    vld_d[0]  = in_vld;
    lane_d[0] = in_lane;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vld_d[i]  = vld_q[i-1];
      lane_d[i] = lane_q[i-1];
    end
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      lane_q <= '0;
    end else begin
      vld_q  <= vld_d;
      lane_q <= lane_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_lane = lane_q[DEPTH-1];

endmodule

// File: rtl/hiscore_ram_arb.sv
// Shares one 16-bit work-RAM port between the game CPU and the hiscore engine.
// CPU owns the port by default and is stalled via cpu_wait while the hiscore side holds it.
module hiscore_ram_arb
  import hiscore_pkg::*;
#(
  parameter int unsigned HS_AW  = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned PAD    = 2
) (
  input  logic             clk_memory,
  input  logic             reset_n,
  input  logic             cpu_cs,
  input  logic             cpu_we,
  input  logic [HS_AW-2:0] cpu_addr,
  input  logic [1:0]       cpu_be,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_wait,
  input  logic [HS_AW-1:0] hs_address,
  input  logic [7:0]       hs_data_in,
  input  logic             hs_write_en,
  input  logic             hs_access_read,
  input  logic             hs_access_write,
  output logic [7:0]       hs_data_out,
  output logic             hs_err,
  output logic [HS_AW-2:0] ram_addr,
  output logic [1:0]       ram_be,
  output logic             ram_we,
  output logic [15:0]      ram_wdata,
  input  logic [15:0]      ram_rdata
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);
  localparam logic [3:0] PAD_C    = 4'(PAD);

  hs_arb_state_t state_q, state_d;
  logic [2:0]    inflight_q, inflight_d;
  logic [3:0]    pad_q, pad_d;
  logic [7:0]    hs_data_out_q, hs_data_out_d;
  logic          hs_err_q, hs_err_d;
  logic          intent;
  logic          cpu_rd_served;
  logic          rd_vld, rd_lane;

  hs_rd_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
    .clk_memory (clk_memory),
    .reset_n    (reset_n),
    .in_vld     (state_q == GRANT),
    .in_lane    (hs_address[0]),
    .out_vld    (rd_vld),
    .out_lane   (rd_lane)
  );

  always_comb begin
    intent        = hs_access_read | hs_access_write;
    cpu_rd_served = (state_q == IDLE) & cpu_cs & ~cpu_we;

    state_d       = state_q;
    pad_d         = pad_q;
    hs_data_out_d = hs_data_out_q;
    hs_err_d      = hs_err_q | (hs_write_en & (state_q != GRANT));
    inflight_d    = cpu_rd_served      ? RD_LAT_C :
                    (inflight_q != '0) ? inflight_q - 3'd1 : 3'd0;

    ram_addr  = '0;
    ram_be    = 2'b00;
    ram_we    = 1'b0;
    ram_wdata = '0;
    cpu_wait  = cpu_cs;

    // Capture only returns whose address was issued while we held the port.
    if (state_q == GRANT && rd_vld) begin
      hs_data_out_d = rd_lane ? ram_rdata[15:8] : ram_rdata[7:0];
    end

    case (state_q)
      IDLE: begin
        cpu_wait  = 1'b0;
        ram_addr  = cpu_cs ? cpu_addr  : '0;
        ram_be    = cpu_cs ? cpu_be    : 2'b00;
        ram_wdata = cpu_cs ? cpu_wdata : '0;
        ram_we    = cpu_cs & cpu_we & reset_n;
        // Skip DRAIN entirely when nothing will still be returning next cycle.
        if (intent) state_d = (inflight_d == '0) ? GRANT : DRAIN;
      end
      DRAIN: begin
        if (inflight_d == '0) state_d = GRANT;
      end
      GRANT: begin
        ram_addr  = hs_address[HS_AW-1:1];
        ram_be    = lane_be(hs_address[0]);
        ram_wdata = {hs_data_in, hs_data_in};
        ram_we    = hs_write_en;
        if (!intent) begin
          state_d = RELEASE;
          pad_d   = PAD_C;
        end
      end
      RELEASE: begin
        pad_d = (pad_q != '0) ? pad_q - 4'd1 : 4'd0;
        if (intent)             state_d = GRANT;
        else if (pad_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      inflight_q    <= '0;
      pad_q         <= '0;
      hs_data_out_q <= '0;
      hs_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      pad_q         <= pad_d;
      hs_data_out_q <= hs_data_out_d;
      hs_err_q      <= hs_err_d;
    end
  end

  assign cpu_rdata   = ram_rdata;
  assign hs_data_out = hs_data_out_q;
  assign hs_err      = hs_err_q;

endmodule
